// File: rtl/lcd_pattern_gen.sv
// Multi-channel pattern generator feeding the LCD controller's data/we/ready port.
// Optional stall counter output is enabled with `define LCDGEN_STALL_CNT_EN.
module lcd_pattern_gen #(
   parameter  int WIDTH = 32,
   parameter  int NCH   = 4,
   parameter  int PER_W = 26,
   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             CLK,
   input  logic             RST_X,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [PER_W-1:0] period,
   input  logic [WIDTH-1:0] seed,
   input  logic             load,
   input  logic             ready,
   output logic [WIDTH-1:0] data,
   output logic             we,
   output logic [CH_W-1:0]  ch,
   output logic             busy
`ifdef LCDGEN_STALL_CNT_EN
   ,
   output logic [15:0]      stall_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, WAIT_TICK, WAIT_RDY, SEND} state_t;

   localparam logic [WIDTH-1:0] LFSR_MASK = WIDTH'(32'hEDB88320);

   state_t           state, state_nx;
   logic [PER_W-1:0] cnt, cnt_nx;
   logic [WIDTH-1:0] chan [NCH];
   logic [CH_W-1:0]  ptr;
   logic [WIDTH-1:0] data_q;
   logic [CH_W-1:0]  ch_q;
   logic [WIDTH-1:0] cur_val;
   logic [WIDTH-1:0] upd_val;

   // Handshake: the controller raises ready when it can take a word; a write is
   // the single SEND cycle (we=1), entered only from WAIT_RDY with ready=1, and
   // ready is not looked at during SEND itself.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: begin
            if (en) begin
               cnt_nx   = period;
               state_nx = WAIT_TICK;
            end
         end
         WAIT_TICK: begin
            if (!en) begin
               state_nx = IDLE;
            end else if (cnt == '0) begin
               cnt_nx   = period;
               state_nx = WAIT_RDY;
            end else begin
               cnt_nx = cnt - PER_W'(1);
            end
         end
         WAIT_RDY: begin
            if (!en)        state_nx = IDLE;
            else if (ready) state_nx = SEND;
         end
         SEND:    state_nx = en ? WAIT_TICK : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign cur_val = chan[ptr];

   always_comb begin
      upd_val = cur_val;
      case (mode)
         2'd0:    upd_val = cur_val + WIDTH'(1);
         2'd1:    upd_val = cur_val - WIDTH'(1);
         2'd2:    upd_val = cur_val[0] ? ((cur_val >> 1) ^ LFSR_MASK) : (cur_val >> 1);
         default: upd_val = cur_val;
      endcase
   end

   // During SEND the live channel value is shown; afterwards the captured copy holds.
   assign we   = (state == SEND);
   assign busy = (state != IDLE);
   assign data = we ? cur_val : data_q;
   assign ch   = we ? ptr : ch_q;

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         state  <= IDLE;
         cnt    <= '0;
         ptr    <= '0;
         data_q <= '0;
         ch_q   <= '0;
         for (int i = 0; i < NCH; i++) chan[i] <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (we) begin
            data_q <= cur_val;
            ch_q   <= ptr;
         end
         // load wins over the SEND update; the word written this cycle is still the old one
         if (load) begin
            for (int i = 0; i < NCH; i++) chan[i] <= seed;
            ptr <= '0;
         end else if (we) begin
            chan[ptr] <= upd_val;
            ptr       <= (ptr == CH_W'(NCH - 1)) ? '0 : ptr + CH_W'(1);
         end
      end
   end

`ifdef LCDGEN_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         stall_q <= '0;
      end else if (load) begin
         stall_q <= '0;
      end else if (state == WAIT_RDY && !ready && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule
